// File: rtl/seg7_scan_decoder_if.sv
// Scan-line bundle between a multiplexed 7-segment display driver and its decoder.
// Ports: seg/sel are the active-low display pins; value/dp_out/valid/err/err_cnt
// are the decoded results. master = pin driver / result observer, slave = decoder.
interface seg7_scan_decoder_if;
    logic [7:0]  seg;
    logic [7:0]  sel;
    logic [31:0] value;
    logic [7:0]  dp_out;
    logic        valid;
    logic        err;
    logic [7:0]  err_cnt;

    modport master (
        output seg, sel,
        input  value, dp_out, valid, err, err_cnt
    );

    modport slave (
        input  seg, sel,
        output value, dp_out, valid, err, err_cnt
    );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Purpose: synchronize/debounce a multiplexed 8-digit 7-seg scan and rebuild the 32-bit displayed word.
// Latency: 2 sync flops + STABLE_CYCLES run filter; value/valid land on the edge that completes the frame.
// Backpressure: none -- pins are sampled every cycle; valid/err are one-cycle pulses, err_cnt saturates.
// Ports: clk (rising edge), rst (async active-low), scan (slave modport: seg/sel in,
//        value/dp_out/valid/err/err_cnt out).
module seg7_scan_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int TIMEOUT       = 200000
) (
    input  logic                clk,
    input  logic                rst,
    seg7_scan_decoder_if.slave  scan
);
    localparam int RUN_W = $clog2(STABLE_CYCLES + 1);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(STABLE_CYCLES);
    localparam logic [RUN_W-1:0] RUN_PRE  = RUN_W'(STABLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic {ST_IDLE, ST_COLLECT} state_t;

    // {sel, seg} synchronizer stages and run-length filter
    logic [15:0]      r_s1;
    logic [15:0]      r_s2;
    logic [RUN_W-1:0] r_run;

    // frame assembly state
    state_t           r_state;
    logic [7:0]       r_mask;
    logic [31:0]      r_digit;
    logic [7:0]       r_dpr;
    logic [TMR_W-1:0] r_tmr;

    // registered outputs
    logic [31:0]      r_value;
    logic [7:0]       r_dp_out;
    logic             r_valid;
    logic             r_err;
    logic [7:0]       r_err_cnt;

    logic             w_accept;
    logic [7:0]       w_sel_act;
    logic             w_blank;
    logic             w_multi;
    logic [4:0]       w_dec;
    logic [2:0]       w_idx;
    logic             w_good;
    logic             w_reject;
    logic             w_timeout;
    logic [7:0]       w_mask_next;
    logic [31:0]      w_digit_next;
    logic [7:0]       w_dpr_next;

    // Returns {recognized, nibble} for an active-low a..g pin pattern.
    function automatic logic [4:0] f_decode(input logic [6:0] p);
        logic [4:0] r;
        case (p)
            7'h40:   r = {1'b1, 4'h0};
            7'h79:   r = {1'b1, 4'h1};
            7'h24:   r = {1'b1, 4'h2};
            7'h30:   r = {1'b1, 4'h3};
            7'h19:   r = {1'b1, 4'h4};
            7'h12:   r = {1'b1, 4'h5};
            7'h02:   r = {1'b1, 4'h6};
            7'h78:   r = {1'b1, 4'h7};
            7'h00:   r = {1'b1, 4'h8};
            7'h10:   r = {1'b1, 4'h9};
            7'h08:   r = {1'b1, 4'hA};
            7'h03:   r = {1'b1, 4'hB};
            7'h46:   r = {1'b1, 4'hC};
            7'h21:   r = {1'b1, 4'hD};
            7'h06:   r = {1'b1, 4'hE};
            7'h0E:   r = {1'b1, 4'hF};
            default: r = 5'b0_0000;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1  <= '0;
            r_s2  <= '0;
            r_run <= '0;
        end else begin
            r_s1 <= {scan.sel, scan.seg};
            r_s2 <= r_s1;
            if (r_s1 != r_s2) begin
                r_run <= RUN_ONE;
            end else if (r_run != RUN_MAX) begin
                r_run <= r_run + RUN_ONE;
            end
        end
    end

    // s2 is about to hold steady for one more edge and the count steps to
    // STABLE_CYCLES on this edge; saturation keeps long runs from re-firing.
    assign w_accept  = (r_s1 == r_s2) && (r_run == RUN_PRE);

    assign w_sel_act = ~r_s2[15:8];
    assign w_blank   = (w_sel_act == 8'h00);
    assign w_multi   = ((w_sel_act & (w_sel_act - 8'd1)) != 8'h00);
    assign w_dec     = f_decode(r_s2[6:0]);

    always_comb begin
        w_idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (w_sel_act[i]) begin
                w_idx = 3'(i);
            end
        end
    end

    assign w_good    = w_accept && !w_blank && !w_multi && w_dec[4];
    assign w_reject  = w_accept && !w_blank && (w_multi || !w_dec[4]);
    // A valid accept on the expiry edge reloads the timer instead.
    assign w_timeout = (r_state == ST_COLLECT) && (r_tmr == TMR_LAST) && !w_good;

    // w_sel_act is one-hot whenever w_good is set, so it doubles as the mask bit.
    assign w_mask_next = r_mask | w_sel_act;

    always_comb begin
        w_digit_next = r_digit;
        w_dpr_next   = r_dpr;
        w_digit_next[{w_idx, 2'b00} +: 4] = w_dec[3:0];
        w_dpr_next[w_idx]                 = ~r_s2[7];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_mask    <= '0;
            r_digit   <= '0;
            r_dpr     <= '0;
            r_tmr     <= '0;
            r_value   <= '0;
            r_dp_out  <= '0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_valid <= 1'b0;
            // reject and timeout on the same edge merge into one pulse
            r_err   <= w_reject || w_timeout;
            if ((w_reject || w_timeout) && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end

            if (w_good) begin
                r_digit <= w_digit_next;
                r_dpr   <= w_dpr_next;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_good) begin
                        r_mask  <= w_mask_next;
                        r_tmr   <= '0;
                        r_state <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (w_good) begin
                        r_tmr <= '0;
                        if (&w_mask_next) begin
                            r_value  <= w_digit_next;
                            r_dp_out <= w_dpr_next;
                            r_valid  <= 1'b1;
                            r_mask   <= '0;
                            r_state  <= ST_IDLE;
                        end else begin
                            r_mask <= w_mask_next;
                        end
                    end else if (w_timeout) begin
                        // digit registers are kept; a cleared mask forces re-capture
                        r_mask  <= '0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_tmr <= r_tmr + TMR_ONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign scan.value   = r_value;
    assign scan.dp_out  = r_dp_out;
    assign scan.valid   = r_valid;
    assign scan.err     = r_err;
    assign scan.err_cnt = r_err_cnt;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scenarios followed by random scan holds,
// each hold compared against a hold-level reference model of the frame rules.
// Clock: 10 time units; outputs sampled on the falling edge.
module tb_seg7_scan_decoder;
    localparam int SC = 4;
    localparam int TO = 100;

    logic clk = 1'b0;
    logic rst;

    seg7_scan_decoder_if scan();

    seg7_scan_decoder #(
        .STABLE_CYCLES(SC),
        .TIMEOUT      (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .scan(scan)
    );

    always #5 clk = ~clk;

    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int checks = 0;
    int errors = 0;

    logic [6:0] segtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // reference model state
    logic [3:0]  m_dig [8];
    logic [7:0]  m_dp;
    logic [7:0]  m_mask;
    bit          m_coll;
    int          m_tlast;
    int          m_errcnt;
    logic [31:0] m_value;
    logic [7:0]  m_dpout;
    logic [15:0] m_prev;
    int          last_err_edge;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int dec(input logic [6:0] p);
        for (int j = 0; j < 16; j++) begin
            if (segtab[j] == p) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_dig[i] = 4'h0;
        m_dp = '0; m_mask = '0; m_coll = 0; m_tlast = 0; m_errcnt = 0;
        m_value = '0; m_dpout = '0; m_prev = 16'h0000;
    endtask

    // Hold pins {s,g} for n cycles, observe pulses, then predict and compare.
    task automatic step(input logic [7:0] s, input logic [7:0] g, input int n);
        int k, t_acc, t_to, nib, zc, idx, exp_v, exp_e, v_cnt, e_cnt;
        bit acc, blank, good, rej, to_hit;
        k = edge_n + 1;
        scan.sel = s;
        scan.seg = g;
        v_cnt = 0;
        e_cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (scan.valid) v_cnt++;
            if (scan.err) begin
                e_cnt++;
                last_err_edge = edge_n;
            end
        end
        // model: a steady run of at least SC cycles is seen once, SC edges after it starts
        acc   = (n >= SC);
        t_acc = k + SC;
        blank = (s == 8'hFF);
        zc    = $countones(~s);
        nib   = dec(g[6:0]);
        idx   = 0;
        for (int i = 0; i < 8; i++) if (!s[i]) idx = i;
        good  = acc && !blank && (zc == 1) && (nib >= 0);
        rej   = acc && !blank && ((zc > 1) || (nib < 0));
        t_to  = m_tlast + TO;
        to_hit = m_coll && (t_to <= k + n - 1) && !(good && (t_acc <= t_to));
        exp_v = 0;
        exp_e = (rej ? 1 : 0) + (to_hit ? 1 : 0) - ((rej && to_hit && (t_to == t_acc)) ? 1 : 0);
        if (to_hit) begin
            m_mask = '0;
            m_coll = 0;
        end
        if (good) begin
            m_dig[idx] = nib[3:0];
            m_dp[idx]  = ~g[7];
            m_mask[idx] = 1'b1;
            m_coll  = 1;
            m_tlast = t_acc;
            if (m_mask == 8'hFF) begin
                exp_v = 1;
                for (int i = 0; i < 8; i++) m_value[i*4 +: 4] = m_dig[i];
                m_dpout = m_dp;
                m_mask  = '0;
                m_coll  = 0;
            end
        end
        m_errcnt = (m_errcnt + exp_e > 255) ? 255 : m_errcnt + exp_e;
        m_prev = {s, g};
        chk("valid_pulses", v_cnt, exp_v);
        chk("err_pulses", e_cnt, exp_e);
        chk("value", scan.value, m_value);
        chk("dp_out", {24'h0, scan.dp_out}, {24'h0, m_dpout});
        chk("err_cnt", {24'h0, scan.err_cnt}, m_errcnt);
    endtask

    task automatic digit(input int i, input int nb, input bit dp, input int n);
        logic [7:0] s;
        logic [6:0] p;
        s = ~(8'h01 << i);
        p = segtab[nb];
        step(s, {~dp, p}, n);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_value"}, scan.value, 32'h0);
        chk({tag, "_dp_out"}, {24'h0, scan.dp_out}, 32'h0);
        chk({tag, "_valid"}, {31'h0, scan.valid}, 32'h0);
        chk({tag, "_err"}, {31'h0, scan.err}, 32'h0);
        chk({tag, "_err_cnt"}, {24'h0, scan.err_cnt}, 32'h0);
    endtask

    initial begin
        int exp_to;
        logic [7:0] s, g;
        int r, n;
        model_reset();
        last_err_edge = -1;
        rst = 1'b0;
        scan.sel = 8'hFF;
        scan.seg = 8'hFF;
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        rst = 1'b1;
        step(8'hFF, 8'hFF, 8);

        // full frame 8,7,...,1 across digits 0..7
        for (int i = 0; i < 8; i++) digit(i, 8 - i, 1'b0, 10);
        chk("t1_value", scan.value, 32'h12345678);
        chk("t1_err_cnt", {24'h0, scan.err_cnt}, 32'h0);

        // 3-cycle glitch on digit 3 must not set its mask bit
        step(8'hF7, 8'h99, 3);
        step(8'hFF, 8'hFF, 8);
        for (int i = 0; i < 8; i++) if (i != 3) digit(i, i, 1'b0, 10);
        chk("t2_no_frame", scan.value, 32'h12345678);
        digit(3, 3, 1'b0, 10);
        chk("t2_value", scan.value, 32'h76543210);

        // two digit enables at once
        step(8'b1111_0011, 8'h80, 10);
        chk("t3_err_cnt", {24'h0, scan.err_cnt}, 32'h1);

        // unrecognized segment pattern, then all-F frame with dp lit
        step(8'hFE, 8'hFE, 10);
        chk("t4_err_cnt", {24'h0, scan.err_cnt}, 32'h2);
        for (int i = 0; i < 8; i++) digit(i, 15, 1'b1, 10);
        chk("t4_value", scan.value, 32'hFFFFFFFF);
        chk("t4_dp_out", {24'h0, scan.dp_out}, 32'hFF);

        // partial frame then long blank: timeout
        for (int i = 0; i < 3; i++) digit(i, 10, 1'b0, 10);
        exp_to = m_tlast + TO;
        step(8'hFF, 8'hFF, 150);
        chk("t5_timeout_edge", last_err_edge, exp_to);
        chk("t5_err_cnt", {24'h0, scan.err_cnt}, 32'h3);
        for (int i = 0; i < 8; i++) digit(i, 10, 1'b0, 10);
        chk("t5_value", scan.value, 32'hAAAAAAAA);

        // reset mid-frame
        for (int i = 0; i < 5; i++) digit(i, 7, 1'b0, 10);
        scan.sel = 8'hFF;
        scan.seg = 8'hFF;
        rst = 1'b0;
        #1;
        chk_zero_outputs("midreset");
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        step(8'hFF, 8'hFF, 8);
        for (int i = 0; i < 8; i++) digit(i, 0, 1'b0, 10);
        chk("t6_value", scan.value, 32'h0);
        chk("t6_dp_out", {24'h0, scan.dp_out}, 32'h0);

        // random scan holds
        for (int t = 0; t < 300; t++) begin
            do begin
                r = $urandom_range(0, 99);
                n = $urandom_range(SC + 2, SC + 8);
                if (r < 3) begin
                    s = 8'hFF; g = 8'hFF; n = $urandom_range(TO - 10, TO + 10);
                end else if (r < 12) begin
                    s = 8'hFF; g = 8'($urandom);
                end else if (r < 20) begin
                    s = ~(8'h01 << $urandom_range(0, 7));
                    g = {1'($urandom), segtab[$urandom_range(0, 15)]};
                    n = $urandom_range(1, SC - 1);
                end else if (r < 26) begin
                    do s = 8'($urandom); while ($countones(~s) < 2);
                    g = 8'($urandom);
                end else if (r < 32) begin
                    s = ~(8'h01 << $urandom_range(0, 7));
                    do g = 8'($urandom); while (dec(g[6:0]) >= 0);
                end else begin
                    s = ~(8'h01 << $urandom_range(0, 7));
                    g = {1'($urandom), segtab[$urandom_range(0, 15)]};
                end
            end while ({s, g} == m_prev);
            step(s, g, n);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
